// File: rtl/rom_loader.sv
// Boot-time program loader: parses a length-prefixed, checksummed byte stream
// from the host link into 16-bit ROM writes and releases the CPU once verified.
module rom_loader #(
  parameter int ROM_DEPTH = 32768
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        rom_write_enabled,
  output logic [15:0] rom_address,
  output logic [15:0] rom_write_value,
  output logic        cpu_rst,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t      state_q, state_d;
  logic        armed_q;
  logic [7:0]  len_hi_q;
  logic [15:0] len_q;
  logic [7:0]  hi_q;
  logic [7:0]  sum_q;
  logic [15:0] idx_q;

  logic        accept;
  logic [15:0] len_word;
  logic [16:0] idx_next;

  assign accept   = byte_valid & byte_ready;
  assign len_word = {len_hi_q, byte_in};
  assign idx_next = {1'b0, idx_q} + 17'd1;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_LEN_HI;
    else     state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it unassigned
  // (which would infer a latch).
  always_comb begin
    state_d = state_q;
    if (accept) begin
      unique case (state_q)
        S_LEN_HI:  state_d = S_LEN_LO;
        S_LEN_LO: begin
          if (len_word == 16'd0)                 state_d = S_CHECK;
          else if (32'(len_word) > ROM_DEPTH)    state_d = S_ERROR;
          else                                   state_d = S_DATA_HI;
        end
        S_DATA_HI: state_d = S_DATA_LO;
        S_DATA_LO: state_d = (idx_next < {1'b0, len_q}) ? S_DATA_HI : S_CHECK;
        S_CHECK:   state_d = (byte_in == sum_q) ? S_DONE : S_ERROR;
        default:   state_d = state_q;
      endcase
    end
  end

  // armed_q keeps byte_ready low until the first edge after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed_q           <= 1'b0;
      len_hi_q          <= '0;
      len_q             <= '0;
      hi_q              <= '0;
      sum_q             <= '0;
      idx_q             <= '0;
      rom_write_enabled <= 1'b0;
      rom_address       <= '0;
      rom_write_value   <= '0;
    end else begin
      armed_q           <= 1'b1;
      rom_write_enabled <= 1'b0;
      if (accept) begin
        unique case (state_q)
          S_LEN_HI:  len_hi_q <= byte_in;
          S_LEN_LO:  len_q    <= len_word;
          S_DATA_HI: begin
            hi_q  <= byte_in;
            sum_q <= sum_q + byte_in;
          end
          S_DATA_LO: begin
            rom_write_enabled <= 1'b1;
            rom_address       <= idx_q;
            rom_write_value   <= {hi_q, byte_in};
            sum_q             <= sum_q + byte_in;
            idx_q             <= idx_q + 16'd1;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    byte_ready = armed_q && (state_q != S_DONE) && (state_q != S_ERROR);
    cpu_rst    = (state_q != S_DONE);
    done       = (state_q == S_DONE);
    error      = (state_q == S_ERROR);
  end

endmodule
